decode_stage: RTL and testbench

//  Registered, XLEN-parametrised RV instruction decode stage between fetch and execute.

---
 rtl/decode_stage_pkg.sv | 27 ++
 rtl/decode_imm_gen.sv | 52 +++++
 rtl/decode_stage.sv | 102 ++++++++++
 tb/tb_decode_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcode constants, one-hot format indices and buffer states for decode_stage.
package decode_stage_pkg;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_OP       = 7'h33;
  localparam logic [6:0] OP_IMM_32   = 7'h1B;
  localparam logic [6:0] OP_OP_32    = 7'h3B;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam int FMT_I   = 0;
  localparam int FMT_U   = 1;
  localparam int FMT_J   = 2;
  localparam int FMT_B   = 3;
  localparam int FMT_S   = 4;
  localparam int FMT_SYS = 5;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;
  function automatic logic is_known_op(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                      OP_IMM, OP_OP, OP_IMM_32, OP_OP_32, OP_SYSTEM, OP_MISC_MEM};
  endfunction
endpackage

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: combinational instruction -> XLEN immediate and one-hot format tag.
// Ports: i_ins (32-bit instruction), o_imm (XLEN immediate), o_fmt ({SYS,S,B,J,U,I}, zero for R/none).
module decode_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_ins,
  output logic [XLEN-1:0] o_imm,
  output logic [5:0]      o_fmt
);
  logic [6:0]      w_op;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_imm_sys;
  assign w_op      = i_ins[6:0];
  assign w_imm_i   = XLEN'($signed(i_ins[31:20]));
  assign w_imm_s   = XLEN'($signed({i_ins[31:25], i_ins[11:7]}));
  assign w_imm_b   = XLEN'($signed({i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0}));
  assign w_imm_j   = XLEN'($signed({i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0}));
  assign w_imm_u   = XLEN'($signed({i_ins[31:12], 12'b0}));
  assign w_imm_sys = XLEN'(i_ins[31:20]);
  always_comb begin
    o_imm = '0;
    o_fmt = '0;
    case (w_op)
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM_32: begin
        o_imm        = w_imm_i;
        o_fmt[FMT_I] = 1'b1;
      end
      OP_STORE: begin
        o_imm        = w_imm_s;
        o_fmt[FMT_S] = 1'b1;
      end
      OP_BRANCH: begin
        o_imm        = w_imm_b;
        o_fmt[FMT_B] = 1'b1;
      end
      OP_JAL: begin
        o_imm        = w_imm_j;
        o_fmt[FMT_J] = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        o_imm        = w_imm_u;
        o_fmt[FMT_U] = 1'b1;
      end
      OP_SYSTEM: begin
        o_imm          = w_imm_sys;
        o_fmt[FMT_SYS] = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV decode stage with a 2-entry buffer between fetch and execute.
// Ports: clk, rst_n (async low), flush (sync); in_valid/in_ready/in_pc/in_ins from fetch;
//   out_valid/out_ready and decoded head entry (pc, opcode, funct3/7, rs1, rs2, rd, csr, imm,
//   fmt, illegal) toward execute.
// Optional macro DECODE_ILLEGAL_EN enables illegal-opcode detection; otherwise out_illegal = 0.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [INS_W-1:0] in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [11:0]      out_csr,
  output logic [XLEN-1:0]  out_imm,
  output logic [5:0]       out_fmt,
  output logic             out_illegal
);
  // Entries keep the raw instruction; the field outputs are plain slices of it.
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [INS_W-1:0] ins;
    logic [XLEN-1:0]  imm;
    logic [5:0]       fmt;
    logic             illegal;
  } entry_t;
  state_t          r_state;
  entry_t          r_head, r_skid, w_new;
  logic [XLEN-1:0] w_imm;
  logic [5:0]      w_fmt;
  logic            w_illegal, w_in_xfer, w_out_xfer;
  decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_ins(in_ins[31:0]),
    .o_imm(w_imm),
    .o_fmt(w_fmt)
  );
`ifdef DECODE_ILLEGAL_EN
  assign w_illegal = !is_known_op(in_ins[6:0]) || (in_ins[1:0] != 2'b11);
`else
  assign w_illegal = 1'b0;
`endif
  assign w_new      = {in_pc, in_ins, w_imm, w_fmt, w_illegal};
  assign in_ready   = r_state != ST_TWO;
  assign out_valid  = r_state != ST_EMPTY;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) begin
          r_head  <= w_new;
          r_state <= ST_ONE;
        end
        ST_ONE: begin
          // Simultaneous in and out: the departing head is replaced by the new entry.
          if (w_in_xfer && !w_out_xfer) begin
            r_skid  <= w_new;
            r_state <= ST_TWO;
          end else if (w_in_xfer) r_head <= w_new;
          else if (w_out_xfer) r_state <= ST_EMPTY;
        end
        ST_TWO: if (w_out_xfer) begin
          r_head  <= r_skid;
          r_state <= ST_ONE;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end
  assign out_pc      = r_head.pc;
  assign out_opcode  = r_head.ins[6:0];
  assign out_funct3  = r_head.ins[14:12];
  assign out_funct7  = r_head.ins[31:25];
  assign out_rs1     = r_head.ins[19:15];
  assign out_rs2     = r_head.ins[24:20];
  assign out_rd      = r_head.ins[11:7];
  assign out_csr     = r_head.ins[31:20];
  assign out_imm     = r_head.imm;
  assign out_fmt     = r_head.fmt;
  assign out_illegal = r_head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage at XLEN 32 and 64 against a queue model.
module tb_decode_stage;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } item_t;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_ins;
  logic a_ready, a_valid, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [6:0] a_op, a_f7;
  logic [2:0] a_f3;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [11:0] a_csr;
  logic [5:0] a_fmt;
  logic b_ready, b_valid, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [6:0] b_op, b_f7;
  logic [2:0] b_f3;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [11:0] b_csr;
  logic [5:0] b_fmt;
  int n_checks = 0;
  int n_fail = 0;
  item_t q[$];
  always #5 clk = ~clk;
  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
    .in_pc(in_pc[31:0]), .in_ins(in_ins), .out_valid(a_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_op), .out_funct3(a_f3), .out_funct7(a_f7), .out_rs1(a_rs1),
    .out_rs2(a_rs2), .out_rd(a_rd), .out_csr(a_csr), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill)
  );
  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
    .in_pc(in_pc), .in_ins(in_ins), .out_valid(b_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_op), .out_funct3(b_f3), .out_funct7(b_f7), .out_rs1(b_rs1),
    .out_rs2(b_rs2), .out_rd(b_rd), .out_csr(b_csr), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_illegal(b_ill)
  );
  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    longint v;
    case (ins[6:0])
      7'h67, 7'h03, 7'h13, 7'h1B: v = longint'($signed(ins[31:20]));
      7'h23: v = longint'($signed({ins[31:25], ins[11:7]}));
      7'h63: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
      7'h6F: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      7'h37, 7'h17: v = longint'($signed(ins[31:12])) * 4096;
      7'h73: v = longint'({20'b0, ins[31:20]});
      default: v = 0;
    endcase
    return 64'(v);
  endfunction
  function automatic logic [5:0] ref_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h67, 7'h03, 7'h13, 7'h1B: return 6'b000001;
      7'h37, 7'h17: return 6'b000010;
      7'h6F: return 6'b000100;
      7'h63: return 6'b001000;
      7'h23: return 6'b010000;
      7'h73: return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction
  function automatic logic ref_ill(input logic [31:0] ins);
`ifdef DECODE_ILLEGAL_EN
    logic [6:0] op;
    op = ins[6:0];
    return !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B,
                        7'h3B, 7'h73, 7'h0F});
`else
    return ins[0] & 1'b0;
`endif
  endfunction
  task automatic push(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_ins = ins; out_ready = ordy; flush = fl;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_ins = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_valid, a_pc, a_imm, a_fmt, a_ill, a_op, a_rd} !== '0 || a_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset32 valid=%b ready=%b pc=%h imm=%h fmt=%b required valid=0 ready=1 rest=0", a_valid, a_ready, a_pc, a_imm, a_fmt);
    end
    n_checks++;
    if ({b_valid, b_pc, b_imm, b_fmt, b_ill, b_csr} !== '0 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset64 valid=%b ready=%b pc=%h imm=%h required valid=0 ready=1 rest=0", b_valid, b_ready, b_pc, b_imm);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_addi;
    push(1'b1, 64'h100, 32'hFFF00093, 1'b0, 1'b0);
    n_checks++;
    if (a_valid !== 1'b1 || a_imm !== 32'hFFFFFFFF || a_rd !== 5'd1 || a_fmt !== 6'b000001 || a_pc !== 32'h100) begin
      n_fail++; $display("FAIL addi valid=%b imm=%h rd=%0d fmt=%b pc=%h required 1 ffffffff 1 000001 100", a_valid, a_imm, a_rd, a_fmt, a_pc);
    end
    push(1'b0, 0, 0, 1'b0, 1'b1);
  endtask
  task automatic test_lui64;
    push(1'b1, 64'h2000, 32'h800002B7, 1'b0, 1'b0);
    n_checks++;
    if (b_imm !== 64'hFFFFFFFF80000000 || b_fmt !== 6'b000010 || b_rd !== 5'd5) begin
      n_fail++; $display("FAIL lui64 imm=%h fmt=%b rd=%0d required ffffffff80000000 000010 5", b_imm, b_fmt, b_rd);
    end
    n_checks++;
    if (a_imm !== 32'h80000000) begin
      n_fail++; $display("FAIL lui32 imm=%h required 80000000", a_imm);
    end
    push(1'b0, 0, 0, 1'b0, 1'b1);
  endtask
  task automatic test_back_to_back;
    push(1'b1, 64'hA0, 32'h00500113, 1'b0, 1'b0);
    push(1'b1, 64'hB0, 32'h00A00193, 1'b0, 1'b0);
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0 || a_pc !== 32'hA0) begin
      n_fail++; $display("FAIL full ready=%b/%b head_pc=%h required 0/0 a0", a_ready, b_ready, a_pc);
    end
    push(1'b1, 64'hC0, 32'h00000013, 1'b0, 1'b0);
    n_checks++;
    if (a_pc !== 32'hA0 || a_imm !== 32'd5) begin
      n_fail++; $display("FAIL full_hold head_pc=%h imm=%h required a0 5", a_pc, a_imm);
    end
    push(1'b0, 0, 0, 1'b1, 1'b0);
    n_checks++;
    if (a_valid !== 1'b1 || a_pc !== 32'hB0 || a_imm !== 32'd10 || a_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_b valid=%b pc=%h imm=%h ready=%b required 1 b0 a 1", a_valid, a_pc, a_imm, a_ready);
    end
    push(1'b0, 0, 0, 1'b1, 1'b0);
    n_checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty valid=%b/%b required 0/0", a_valid, b_valid);
    end
  endtask
  task automatic test_flush;
    push(1'b1, 64'h10, 32'h00100093, 1'b0, 1'b0);
    push(1'b1, 64'h14, 32'h00200093, 1'b0, 1'b0);
    push(1'b1, 64'h18, 32'h00300093, 1'b0, 1'b1);
    n_checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_fmt !== 6'b0 || b_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_two valid=%b ready=%b fmt=%b required 0 1 000000", a_valid, a_ready, a_fmt);
    end
    push(1'b1, 64'h20, 32'h00400093, 1'b1, 1'b0);
    push(1'b1, 64'h24, 32'h00500093, 1'b1, 1'b1);
    push(1'b0, 0, 0, 1'b1, 1'b0);
    n_checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_one_drop valid=%b/%b required 0/0", a_valid, b_valid);
    end
  endtask
  task automatic test_illegal;
    logic exp;
`ifdef DECODE_ILLEGAL_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    push(1'b1, 64'h30, 32'h0000007F, 1'b0, 1'b0);
    n_checks++;
    if (a_ill !== exp || b_ill !== exp || a_valid !== 1'b1) begin
      n_fail++; $display("FAIL illegal_7f got=%b/%b valid=%b required %b", a_ill, b_ill, a_valid, exp);
    end
    push(1'b1, 64'h34, 32'h00000013, 1'b1, 1'b0);
    n_checks++;
    if (a_ill !== 1'b0 || a_pc !== 32'h34) begin
      n_fail++; $display("FAIL illegal_addi got=%b pc=%h required 0 34", a_ill, a_pc);
    end
    push(1'b0, 0, 0, 1'b0, 1'b1);
  endtask
  task automatic test_async_reset;
    push(1'b1, 64'h40, 32'hFFF00093, 1'b0, 1'b0);
    push(1'b1, 64'h44, 32'h800002B7, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_valid, a_pc, a_imm, a_fmt, a_ill, a_rd, b_valid, b_pc, b_imm, b_fmt} !== '0) begin
      n_fail++; $display("FAIL async_reset valid=%b pc=%h imm=%h fmt=%b required all 0", a_valid, a_pc, a_imm, a_fmt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release ready=%b/%b valid=%b required 1/1 0", a_ready, b_ready, a_valid);
    end
  endtask
  task automatic test_random;
    logic [6:0] ops [16] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                             7'h33, 7'h1B, 7'h3B, 7'h73, 7'h0F, 7'h7F, 7'h10, 7'h5B};
    logic v, o, f, in_x, out_x, ev, er;
    logic [31:0] r, ins;
    logic [63:0] pc, ei;
    item_t e;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      ev = q.size() > 0;
      er = q.size() < 2;
      n_checks++;
      if (a_valid !== ev || b_valid !== ev || a_ready !== er || b_ready !== er) begin
        n_fail++; $display("FAIL rand_hs cyc=%0d valid=%b/%b ready=%b/%b required %b %b", c, a_valid, b_valid, a_ready, b_ready, ev, er);
      end
      if (ev) begin
        e = q[0];
        ei = ref_imm(e.ins);
        n_checks++;
        if ({a_pc, a_op, a_f3, a_f7, a_rs1, a_rs2, a_rd, a_csr, a_imm, a_fmt, a_ill} !==
            {e.pc[31:0], e.ins[6:0], e.ins[14:12], e.ins[31:25], e.ins[19:15], e.ins[24:20],
             e.ins[11:7], e.ins[31:20], ei[31:0], ref_fmt(e.ins), ref_ill(e.ins)}) begin
          n_fail++; $display("FAIL rand32 cyc=%0d ins=%h pc=%h imm=%h fmt=%b ill=%b required pc=%h imm=%h fmt=%b ill=%b", c, e.ins, a_pc, a_imm, a_fmt, a_ill, e.pc[31:0], ei[31:0], ref_fmt(e.ins), ref_ill(e.ins));
        end
        n_checks++;
        if ({b_pc, b_op, b_rd, b_csr, b_imm, b_fmt, b_ill} !==
            {e.pc, e.ins[6:0], e.ins[11:7], e.ins[31:20], ei, ref_fmt(e.ins), ref_ill(e.ins)}) begin
          n_fail++; $display("FAIL rand64 cyc=%0d ins=%h pc=%h imm=%h fmt=%b required pc=%h imm=%h fmt=%b", c, e.ins, b_pc, b_imm, b_fmt, e.pc, ei, ref_fmt(e.ins));
        end
      end
      r = $urandom;
      ins = {r[31:7], ops[$urandom_range(0, 15)]};
      if ($urandom_range(0, 7) == 0) ins[1:0] = 2'(r[1:0]);
      pc = {$urandom, $urandom};
      v = $urandom_range(0, 3) != 0;
      o = $urandom_range(0, 2) != 0;
      f = $urandom_range(0, 24) == 0;
      in_x = v && er;
      out_x = ev && o;
      push(v, pc, ins, o, f);
      if (f) q.delete();
      else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back('{pc: pc, ins: ins});
      end
    end
  endtask
  initial begin
    test_reset;
    test_addi;
    test_lui64;
    test_back_to_back;
    test_flush;
    test_illegal;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
